// File: rtl/dut_clk_pkg.sv
// Shared encodings and default constants for the DUT clock sequencer.
// Unused mode code 2'b11 is folded onto STOP by norm_mode().
package dut_clk_pkg;

  typedef enum logic [2:0] {
    ST_POR,
    ST_DRST,
    ST_RUN,
    ST_PARK,
    ST_STEP_HI,
    ST_STEP_LO
  } seq_state_t;

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_STOP = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  localparam int unsigned DEF_DIV_W           = 16;
  localparam int unsigned DEF_DEFAULT_DIV     = 5000;
  localparam int unsigned DEF_POR_CYCLES      = 1023;
  localparam int unsigned DEF_DUT_RST_EDGES   = 8;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 120000;

  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == MODE_RUN || m == MODE_STEP) ? m : MODE_STOP;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: two-flop synchroniser, consecutive-sample filter and a
// one-cycle pulse on each debounced press.
module btn_debounce
  import dut_clk_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_12,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [1:0]       sync_q;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // cnt tracks how many consecutive samples have disagreed with the level
  always_ff @(posedge clk_12) begin
    if (rst) begin
      sync_q <= '0;
      level  <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      rise   <= 1'b0;
      if (sync_q[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync_q[1];
        cnt   <= '0;
        rise  <= sync_q[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dut_clock_sequencer.sv
// Generates a divided, stoppable, single-steppable clock for a DUT together
// with power-on and button-driven DUT reset sequencing.
module dut_clock_sequencer
  import dut_clk_pkg::*;
#(
  parameter int unsigned DIV_W           = DEF_DIV_W,
  parameter int unsigned DEFAULT_DIV     = DEF_DEFAULT_DIV,
  parameter int unsigned POR_CYCLES      = DEF_POR_CYCLES,
  parameter int unsigned DUT_RST_EDGES   = DEF_DUT_RST_EDGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic             clk_12,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic [DIV_W-1:0] div_value,
  input  logic             div_load,
  input  logic [1:0]       mode,
  input  logic             step_btn,
  input  logic             rst_btn,
  output logic             clk_dut,
  output logic             dut_rst_n,
  output logic             dut_edge,
  output logic             por_done,
  output logic             step_busy
);

  localparam int unsigned POR_W  = $clog2(POR_CYCLES + 2);
  localparam int unsigned EDGE_W = $clog2(DUT_RST_EDGES + 2);

  seq_state_t        state;
  logic [POR_W-1:0]  por_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic [DIV_W-1:0]  half_cnt;
  logic [DIV_W-1:0]  div_reg;
  logic [DIV_W-1:0]  div_shadow;
  logic              step_rise;
  logic              rst_rise;
  logic              at_toggle;
  logic [DIV_W-1:0]  next_div;
  logic [1:0]        eff_mode;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk_12(clk_12), .rst(rst), .btn(step_btn), .rise(step_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst_db (
    .clk_12(clk_12), .rst(rst), .btn(rst_btn), .rise(rst_rise)
  );

  // A load arriving on the toggle cycle itself must govern the next half
  assign at_toggle = (half_cnt == div_reg);
  assign next_div  = div_load ? div_value : div_shadow;
  assign eff_mode  = norm_mode(mode);

  always_ff @(posedge clk_12) begin
    if (rst) begin
      state      <= ST_POR;
      por_cnt    <= POR_W'(POR_CYCLES);
      edge_cnt   <= '0;
      half_cnt   <= '0;
      div_reg    <= DIV_W'(DEFAULT_DIV);
      div_shadow <= DIV_W'(DEFAULT_DIV);
      clk_dut    <= 1'b0;
      dut_rst_n  <= 1'b0;
      dut_edge   <= 1'b0;
      por_done   <= 1'b0;
      step_busy  <= 1'b0;
    end else begin
      dut_edge <= 1'b0;
      if (div_load) div_shadow <= div_value;

      if (state != ST_POR && !pll_locked) begin
        state     <= ST_POR;
        por_cnt   <= POR_W'(POR_CYCLES);
        edge_cnt  <= '0;
        half_cnt  <= '0;
        clk_dut   <= 1'b0;
        dut_rst_n <= 1'b0;
        por_done  <= 1'b0;
        step_busy <= 1'b0;
      end else if (state != ST_POR && state != ST_DRST && rst_rise) begin
        state     <= ST_DRST;
        edge_cnt  <= '0;
        half_cnt  <= '0;
        clk_dut   <= 1'b0;
        dut_rst_n <= 1'b0;
        step_busy <= 1'b0;
      end else begin
        case (state)
          ST_POR: begin
            if (pll_locked) begin
              if (por_cnt <= POR_W'(1)) begin
                por_cnt  <= '0;
                por_done <= 1'b1;
                state    <= ST_DRST;
                edge_cnt <= '0;
                half_cnt <= '0;
                clk_dut  <= 1'b0;
              end else begin
                por_cnt <= por_cnt - 1'b1;
              end
            end
          end
          ST_DRST: begin
            if (at_toggle) begin
              half_cnt <= '0;
              div_reg  <= next_div;
              clk_dut  <= ~clk_dut;
              if (!clk_dut) begin
                dut_edge <= 1'b1;
                if (edge_cnt == EDGE_W'(DUT_RST_EDGES - 1)) state <= ST_RUN;
                else edge_cnt <= edge_cnt + 1'b1;
              end
            end else begin
              half_cnt <= half_cnt + 1'b1;
            end
          end
          ST_RUN: begin
            dut_rst_n <= 1'b1;
            if (at_toggle) begin
              half_cnt <= '0;
              div_reg  <= next_div;
              if (clk_dut) begin
                clk_dut <= 1'b0;
                if (eff_mode != MODE_RUN) state <= ST_PARK;
              end else begin
                clk_dut  <= 1'b1;
                dut_edge <= 1'b1;
              end
            end else begin
              half_cnt <= half_cnt + 1'b1;
            end
          end
          ST_PARK: begin
            clk_dut  <= 1'b0;
            half_cnt <= '0;
            if (eff_mode == MODE_RUN) begin
              state <= ST_RUN;
            end else if (eff_mode == MODE_STEP && step_rise) begin
              state     <= ST_STEP_HI;
              clk_dut   <= 1'b1;
              dut_edge  <= 1'b1;
              step_busy <= 1'b1;
            end
          end
          ST_STEP_HI: begin
            if (at_toggle) begin
              half_cnt <= '0;
              div_reg  <= next_div;
              clk_dut  <= 1'b0;
              state    <= ST_STEP_LO;
            end else begin
              half_cnt <= half_cnt + 1'b1;
            end
          end
          ST_STEP_LO: begin
            if (at_toggle) begin
              half_cnt  <= '0;
              div_reg   <= next_div;
              step_busy <= 1'b0;
              state     <= ST_PARK;
            end else begin
              half_cnt <= half_cnt + 1'b1;
            end
          end
          default: state <= ST_POR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dut_clock_sequencer.sv
// Self-checking bench for dut_clock_sequencer with small parameters; expected
// timings come from half-period and debounce arithmetic, not from the RTL.
module tb_dut_clock_sequencer;

  localparam int DIV_W           = 16;
  localparam int DEFAULT_DIV     = 2;
  localparam int POR_CYCLES      = 4;
  localparam int DUT_RST_EDGES   = 2;
  localparam int DEBOUNCE_CYCLES = 3;
  localparam int STEP_LATENCY    = 2 + DEBOUNCE_CYCLES + 1;

  logic             clk_12 = 1'b0;
  logic             rst;
  logic             pll_locked;
  logic [DIV_W-1:0] div_value;
  logic             div_load;
  logic [1:0]       mode;
  logic             step_btn;
  logic             rst_btn;
  logic             clk_dut;
  logic             dut_rst_n;
  logic             dut_edge;
  logic             por_done;
  logic             step_busy;

  int checks = 0;
  int errors = 0;

  int   riseCount = 0;
  int   highCount = 0;
  int   busyCount = 0;
  logic prevClk   = 1'b0;

  dut_clock_sequencer #(
    .DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV), .POR_CYCLES(POR_CYCLES),
    .DUT_RST_EDGES(DUT_RST_EDGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .clk_12(clk_12), .rst(rst), .pll_locked(pll_locked), .div_value(div_value),
    .div_load(div_load), .mode(mode), .step_btn(step_btn), .rst_btn(rst_btn),
    .clk_dut(clk_dut), .dut_rst_n(dut_rst_n), .dut_edge(dut_edge),
    .por_done(por_done), .step_busy(step_busy)
  );

  always #5 clk_12 = ~clk_12;

  // Running tallies of the generated clock, read as deltas by the main sequence
  always @(negedge clk_12) begin
    if (clk_dut === 1'b1 && prevClk !== 1'b1) riseCount++;
    if (clk_dut === 1'b1) highCount++;
    if (step_busy === 1'b1) busyCount++;
    prevClk = clk_dut;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed no finish expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_12);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic sb, input logic rb, input logic [1:0] md);
    step_btn = sb;
    rst_btn  = rb;
    mode     = md;
  endtask

  task automatic loadDiv(input int d);
    div_value = DIV_W'(d);
    div_load  = 1'b1;
    tick(1);
    div_load  = 1'b0;
  endtask

  function automatic logic sigOf(input int sel);
    case (sel)
      0:       return clk_dut;
      1:       return por_done;
      2:       return dut_rst_n;
      default: return step_busy;
    endcase
  endfunction

  task automatic waitSig(input int sel, input logic lvl, output int n);
    n = 0;
    while (sigOf(sel) !== lvl && n < 60) begin
      @(negedge clk_12);
      n++;
    end
    checks++;
    assert (sigOf(sel) === lvl) else begin
      errors++;
      $error("[TB] FAIL wait_sel%0d observed %b expected %b", sel, sigOf(sel), lvl);
      n = -1;
    end
  endtask

  task automatic syncRise();
    int n;
    waitSig(0, 1'b0, n);
    waitSig(0, 1'b1, n);
  endtask

  task automatic checkDrst(input string p, input int d);
    int n;
    waitSig(0, 1'b1, n);
    checkOutput({p, "_first_rise"}, n, d + 1);
    checkOutput({p, "_edge_pulse"}, dut_edge, 1);
    checkOutput({p, "_rstn_held1"}, dut_rst_n, 0);
    tick(1);
    checkOutput({p, "_edge_clear"}, dut_edge, 0);
    waitSig(0, 1'b0, n);
    checkOutput({p, "_high"}, n + 1, d + 1);
    waitSig(0, 1'b1, n);
    checkOutput({p, "_low"}, n, d + 1);
    checkOutput({p, "_rstn_held2"}, dut_rst_n, 0);
    tick(1);
    checkOutput({p, "_rstn_release"}, dut_rst_n, 1);
  endtask

  task automatic checkBoot(input string p);
    int n;
    waitSig(1, 1'b1, n);
    checkOutput({p, "_por_cycles"}, n, POR_CYCLES);
    checkOutput({p, "_clk_low"}, clk_dut, 0);
    checkDrst(p, DEFAULT_DIV);
  endtask

  initial begin
    int n, cur, d, j, r0, h0, b0;
    rst = 1'b1; pll_locked = 1'b1; div_value = '0; div_load = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'b00);
    tick(3);
    checkOutput("rst_clk", clk_dut, 0);
    checkOutput("rst_rstn", dut_rst_n, 0);
    checkOutput("rst_edge", dut_edge, 0);
    checkOutput("rst_por", por_done, 0);
    checkOutput("rst_busy", step_busy, 0);
    rst = 1'b0;
    checkBoot("boot");

    $display("[TB] PLL loss in RUN");
    tick(4);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    checkOutput("pll_clk", clk_dut, 0);
    checkOutput("pll_rstn", dut_rst_n, 0);
    checkOutput("pll_por", por_done, 0);
    checkBoot("reboot");

    $display("[TB] divider reload mid high phase");
    syncRise();
    tick(1);
    loadDiv(0);
    waitSig(0, 1'b0, n);
    checkOutput("div0_high_kept", n + 2, DEFAULT_DIV + 1);
    waitSig(0, 1'b1, n);
    checkOutput("div0_low", n, 1);
    waitSig(0, 1'b0, n);
    checkOutput("div0_high", n, 1);

    $display("[TB] randomized divider reloads");
    cur = 0;
    for (int i = 0; i < 6; i++) begin
      d = $urandom_range(0, 4);
      j = (i == 0) ? cur : $urandom_range(0, cur);
      syncRise();
      tick(j);
      loadDiv(d);
      waitSig(0, 1'b0, n);
      checkOutput("rnd_high_kept", j + 1 + n, cur + 1);
      waitSig(0, 1'b1, n);
      checkOutput("rnd_low_new", n, d + 1);
      waitSig(0, 1'b0, n);
      checkOutput("rnd_high_new", n, d + 1);
      cur = d;
    end

    $display("[TB] park and step with divider 5");
    syncRise();
    loadDiv(5);
    waitSig(0, 1'b0, n);
    waitSig(0, 1'b1, n);
    checkOutput("d5_low", n, 6);
    applyStimulus(1'b0, 1'b0, 2'b10);
    waitSig(0, 1'b0, n);
    checkOutput("park_high_finish", n, 6);
    r0 = riseCount;
    tick(10);
    checkOutput("parked_quiet", riseCount - r0, 0);
    checkOutput("parked_busy", step_busy, 0);
    r0 = riseCount; h0 = highCount; b0 = busyCount;
    applyStimulus(1'b1, 1'b0, 2'b10);
    tick(4);
    applyStimulus(1'b0, 1'b0, 2'b10);
    tick(3);
    applyStimulus(1'b1, 1'b0, 2'b10);
    tick(4);
    applyStimulus(1'b0, 1'b0, 2'b10);
    tick(25);
    checkOutput("busy_press_rises", riseCount - r0, 1);
    checkOutput("d5_step_high", highCount - h0, 6);
    checkOutput("d5_step_busy", busyCount - b0, 12);

    $display("[TB] park to run, then step with divider 2");
    applyStimulus(1'b0, 1'b0, 2'b00);
    waitSig(0, 1'b1, n);
    checkOutput("park_to_run_rise", n, 5 + 2);
    loadDiv(2);
    waitSig(0, 1'b0, n);
    waitSig(0, 1'b1, n);
    checkOutput("d2_low", n, 3);
    applyStimulus(1'b0, 1'b0, 2'b10);
    waitSig(0, 1'b0, n);
    checkOutput("d2_park_high", n, 3);
    tick(5);
    r0 = riseCount; h0 = highCount; b0 = busyCount;
    applyStimulus(1'b1, 1'b0, 2'b10);
    tick(4);
    applyStimulus(1'b0, 1'b0, 2'b10);
    waitSig(0, 1'b1, n);
    checkOutput("step_latency", n + 4, STEP_LATENCY);
    tick(15);
    checkOutput("step_rises", riseCount - r0, 1);
    checkOutput("step_high", highCount - h0, 3);
    checkOutput("step_busy_len", busyCount - b0, 6);

    $display("[TB] two-cycle step glitch");
    r0 = riseCount; b0 = busyCount;
    applyStimulus(1'b1, 1'b0, 2'b10);
    tick(2);
    applyStimulus(1'b0, 1'b0, 2'b10);
    tick(20);
    checkOutput("glitch_rises", riseCount - r0, 0);
    checkOutput("glitch_busy", busyCount - b0, 0);

    $display("[TB] DUT reset button during step high phase");
    applyStimulus(1'b1, 1'b0, 2'b10);
    tick(2);
    applyStimulus(1'b1, 1'b1, 2'b10);
    tick(2);
    applyStimulus(1'b0, 1'b1, 2'b10);
    tick(2);
    checkOutput("stephi_clk", clk_dut, 1);
    checkOutput("stephi_busy", step_busy, 1);
    applyStimulus(1'b0, 1'b0, 2'b10);
    tick(2);
    checkOutput("btnrst_clk", clk_dut, 0);
    checkOutput("btnrst_rstn", dut_rst_n, 0);
    checkOutput("btnrst_busy", step_busy, 0);
    checkDrst("btnrst", DEFAULT_DIV);

    tick(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dut_clock_sequencer.md
DUT_CLOCK_SEQUENCER -- requirements
Module: dut_clock_sequencer

Interface
REQ-001 SHALL have parameter DIV_W, default 16: divider width.
REQ-002 SHALL have parameter DEFAULT_DIV, default 5000: divider value after reset.
REQ-003 SHALL have parameter POR_CYCLES, default 1023: locked clk_12 cycles before POR completes.
REQ-004 SHALL have parameter DUT_RST_EDGES, default 8: clk_dut rising edges with DUT reset held.
REQ-005 SHALL have parameter DEBOUNCE_CYCLES, default 120000: stable samples needed by the button filter.
REQ-006 SHALL have port clk_12, in, 1: system clock. Reset is rst, synchronous, active-high; clock is clk_12.
REQ-007 SHALL have port rst, in, 1: synchronous active-high reset.
REQ-008 SHALL have port pll_locked, in, 1: PLL lock.
REQ-009 SHALL have port div_value, in, DIV_W: new half-period divider value.
REQ-010 SHALL have port div_load, in, 1: one-cycle strobe that captures div_value.
REQ-011 SHALL have port mode, in, 2: 00 RUN, 01 STOP, 10 STEP, 11 treated as STOP.
REQ-012 SHALL have port step_btn, in, 1: raw asynchronous step button, active-high.
REQ-013 SHALL have port rst_btn, in, 1: raw asynchronous DUT-reset button, active-high.
REQ-014 SHALL have port clk_dut, out, 1: generated DUT clock.
REQ-015 SHALL have port dut_rst_n, out, 1: DUT reset, active-low.
REQ-016 SHALL have port dut_edge, out, 1: one-cycle pulse coincident with each clk_dut 0->1 transition.
REQ-017 SHALL have port por_done, out, 1: POR complete.
REQ-018 SHALL have port step_busy, out, 1: single-step period in progress.

Function
REQ-019 SHALL be a state machine with states POR, DRST, RUN, PARK, STEP_HI and STEP_LO.
REQ-020 SHALL, in POR, load a counter with POR_CYCLES and decrement it only in cycles where pll_locked=1.
REQ-021 SHALL set por_done=1 and go POR->DRST when the POR counter reaches 0.
REQ-022 SHALL clear por_done, force clk_dut=0 and dut_rst_n=0, and return to POR with the counter reloaded when pll_locked=0 in any state other than POR.
REQ-023 SHALL make the divider toggle clk_dut when the half-period count equals div_reg, then clear the count.
REQ-024 SHALL give a clk_dut period of 2*(div_reg+1) clk_12 cycles; div_reg=0 gives period 2.
REQ-025 SHALL capture div_value on div_load into a shadow register.
REQ-026 SHALL transfer the shadow register into div_reg only at the next toggle point, so no half-period is ever truncated.
REQ-027 SHALL, when div_load coincides with a toggle, make the new value govern the following half-period.
REQ-028 SHALL, in DRST, run clk_dut regardless of mode and hold dut_rst_n=0.
REQ-029 SHALL leave DRST after DUT_RST_EDGES rising edges of clk_dut, set dut_rst_n=1 on the clk_12 cycle after that edge, and go to RUN.
REQ-030 SHALL re-enter DRST from RUN, PARK, STEP_HI or STEP_LO on a debounced rst_btn press, restarting the edge count.
REQ-031 SHALL keep clk_dut toggling in RUN.
REQ-032 SHALL, in RUN with mode STOP or STEP, finish any high phase and go to PARK at the next falling toggle.
REQ-033 SHALL hold clk_dut=0 in PARK with the divider count cleared.
REQ-034 SHALL go PARK->RUN on mode RUN, with the first rising edge div_reg+1 cycles later.
REQ-035 SHALL go PARK->STEP_HI when mode=STEP and a debounced step_btn rising event occurs, with clk_dut=1 on the next cycle.
REQ-036 SHALL go STEP_HI->STEP_LO after one half-period.
REQ-037 SHALL go STEP_LO->PARK after one half-period.
REQ-038 SHALL assert step_busy in STEP_HI and STEP_LO.
REQ-039 SHALL ignore step presses while step_busy=1.
REQ-040 SHALL not abort a step in progress on a mode change; the step completes and the mode is then re-evaluated in PARK.
REQ-041 SHALL give rst_btn priority when an rst_btn press and a step press occur in the same cycle.
REQ-042 SHALL synchronise each button with two flops.
REQ-043 SHALL change a debounced button level only after DEBOUNCE_CYCLES consecutive equal synchronised samples.
REQ-044 SHALL emit a one-cycle rise pulse from the button filter on each debounced 0->1 transition.

Reset
REQ-045 SHALL, while rst=1, enter POR.
REQ-046 SHALL set clk_dut=0, dut_rst_n=0, dut_edge=0, por_done=0 and step_busy=0 on rst=1.
REQ-047 SHALL set div_reg and the shadow register to DEFAULT_DIV on rst=1.
REQ-048 SHALL clear the divider count, edge counter and debounce state on rst=1.
REQ-049 SHALL make rst override all other inputs in the same cycle.

Structure
REQ-050 SHALL place the state encoding, the mode encodings (MODE_RUN, MODE_STOP, MODE_STEP) and the default parameter constants in the shared package dut_clk_pkg.
REQ-051 SHALL implement the synchroniser, filter and rise pulse as sub-module btn_debounce, instantiated twice.

Verification (POR_CYCLES=4, DEFAULT_DIV=2, DUT_RST_EDGES=2, DEBOUNCE_CYCLES=3)
REQ-052 SHALL cover: rst released with pll_locked=1 -> por_done=1 after 4 cycles, clk_dut period 6, dut_rst_n=1 one cycle after the 2nd rising edge.
REQ-053 SHALL cover: pll_locked pulled low for 1 cycle in RUN -> clk_dut=0, dut_rst_n=0, por_done=0 next cycle, and the full sequence restarts.
REQ-054 SHALL cover: div_load with div_value=0 mid-high-phase -> current half-period stays 3 cycles, then period 2.
REQ-055 SHALL cover: mode=STEP, step_btn held 4 cycles -> exactly one clk_dut pulse (3 high, 3 low), step_busy high 6 cycles, a second press during busy ignored.
REQ-056 SHALL cover: step_btn glitch of 2 cycles -> no step.
REQ-057 SHALL cover: rst_btn press during STEP_HI -> DRST entered, dut_rst_n=0 for 2 rising edges, then RUN.
